inv_timing_board: RTL and testbench

Clocked behavioural measurement board for characterising an inverter's falling-output timing. It accepts a logic stimulus plus real-valued electrical settings: input transition time, extra input delay and output load. It drives the modelled inverter output, times each falling transition at clock resolution, and reports it as a real number in seconds. It sits between a characterisation bench, which sweeps slope × load and writes Liberty-style tables, and the inverter delay model it contains.

---
 rtl/inv_timing_board.sv | 116 +++++++++++
 tb/tb_inv_timing_board.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/inv_timing_board.sv
// Behavioural board that drives a modelled inverter output from a logic stimulus
// and times each falling output transition at clock resolution.
`timescale 1ns/1ps
module inv_timing_board #(
  parameter real CLK_PERIOD  = 1.0e-12,
  parameter real T_INTR_FALL = 10.0e-12,
  parameter real R_FALL      = 2.0e3,
  parameter real K_FALL      = 0.5,
  parameter real T_INTR_RISE = 12.0e-12,
  parameter real R_RISE      = 3.0e3,
  parameter real K_RISE      = 0.5,
  parameter int  CNT_W       = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic din_logic,
  input  real  tt_val,
  input  real  delay_val,
  input  real  load_capacitor_val,
  output logic dout_electrical,
  output real  propagation_time_fall
);

  typedef enum logic [1:0] {IDLE_HI, IDLE_LO, WAIT_FALL, WAIT_RISE} state_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam real CNT_MAX = (2.0 ** CNT_W) - 1.0;

  state_t state_q;
  logic   sync1_q, sync2_q, prev_q;
  logic   edge_det;
  cnt_t   cnt_q;
  cnt_t   load_ticks;
  real    np_q;
  real    tt_c, dl_c, c_c, nd_r, np_r, tot_r;

  // Round half away from zero; the small bias absorbs binary representation
  // error on exact half-tick values such as tt/2 = 0.5 ps.
  function automatic real round_ticks(input real t);
    return $floor(t / CLK_PERIOD + 0.5 + 1.0e-6);
  endfunction

  function automatic real clamp0(input real v);
    return (v < 0.0) ? 0.0 : v;
  endfunction

  assign edge_det = sync2_q ^ prev_q;

  // Settings only matter in the edge-detect cycle, where the results are captured.
  always_comb begin
    tt_c  = clamp0(tt_val);
    dl_c  = clamp0(delay_val);
    c_c   = clamp0(load_capacitor_val);
    nd_r  = round_ticks(dl_c + tt_c / 2.0);
    np_r  = 0.0;
    if (sync2_q) np_r = round_ticks(T_INTR_FALL + R_FALL * c_c + K_FALL * tt_c);
    else         np_r = round_ticks(T_INTR_RISE + R_RISE * c_c + K_RISE * tt_c);
    if (np_r < 1.0) np_r = 1.0;
    tot_r = nd_r + np_r;
    if (tot_r > CNT_MAX) tot_r = CNT_MAX;
    load_ticks = cnt_t'($rtoi(tot_r));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q               <= 1'b0;
      sync2_q               <= 1'b0;
      prev_q                <= 1'b0;
      state_q               <= IDLE_HI;
      cnt_q                 <= '0;
      np_q                  <= 0.0;
      dout_electrical       <= 1'b1;
      propagation_time_fall <= 0.0;
    end else begin
      sync1_q <= din_logic;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (edge_det) begin
        // Any new edge aborts a pending transition; if the output already sits
        // at the new target level there is nothing left to schedule.
        if (!sync2_q == dout_electrical) begin
          state_q <= dout_electrical ? IDLE_HI : IDLE_LO;
          cnt_q   <= '0;
        end else begin
          state_q <= sync2_q ? WAIT_FALL : WAIT_RISE;
          cnt_q   <= load_ticks;
          np_q    <= np_r;
        end
      end else begin
        case (state_q)
          WAIT_FALL: begin
            if (cnt_q == cnt_t'(1)) begin
              dout_electrical       <= 1'b0;
              propagation_time_fall <= np_q * CLK_PERIOD;
              state_q               <= IDLE_LO;
              cnt_q                 <= '0;
            end else begin
              cnt_q <= cnt_q - cnt_t'(1);
            end
          end
          WAIT_RISE: begin
            if (cnt_q == cnt_t'(1)) begin
              dout_electrical <= 1'b1;
              state_q         <= IDLE_HI;
              cnt_q           <= '0;
            end else begin
              cnt_q <= cnt_q - cnt_t'(1);
            end
          end
          default: cnt_q <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inv_timing_board.sv
// Bench for inv_timing_board: directed timing cases, glitches, saturation, reset
// and a randomised slope x load sweep checked against an arithmetic delay model.
`timescale 1ns/1ps
module tb_inv_timing_board;

  localparam real CLK = 1.0e-12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  real  tt_val = 0.0, delay_val = 0.0, load_val = 0.0;
  logic dout, dout_s;
  real  prop, prop_s;

  int   n_checks = 0;
  int   n_err = 0;
  real  last_fall = 0.0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  inv_timing_board dut (
    .clk(clk), .rst(rst), .din_logic(din),
    .tt_val(tt_val), .delay_val(delay_val), .load_capacitor_val(load_val),
    .dout_electrical(dout), .propagation_time_fall(prop)
  );

  // Narrow counter copy used only to observe counter saturation.
  inv_timing_board #(.CNT_W(8)) dut_s (
    .clk(clk), .rst(rst), .din_logic(din),
    .tt_val(tt_val), .delay_val(delay_val), .load_capacitor_val(load_val),
    .dout_electrical(dout_s), .propagation_time_fall(prop_s)
  );

  task automatic check(input string tag, input real got, input real exp);
    n_checks++;
    if ((got - exp) > 1.0e-18 || (exp - got) > 1.0e-18) begin
      n_err++;
      $display("FAIL %s: got %g expected %g", tag, got, exp);
    end
  endtask

  function automatic longint rnd(input real x);
    return longint'($rtoi($floor(x + 0.5 + 1.0e-6)));
  endfunction

  // Delay model: returns input-delay ticks, propagation ticks and the saturated total.
  task automatic model(input real tt, input real dl, input real c, input bit rising,
                       input int cnt_w, output longint nd, output longint np,
                       output longint tot);
    real t, d, l, ps;
    longint mx;
    t = (tt < 0.0) ? 0.0 : tt;
    d = (dl < 0.0) ? 0.0 : dl;
    l = (c < 0.0) ? 0.0 : c;
    nd = rnd((d + t / 2.0) / CLK);
    if (rising) ps = 10.0e-12 + 2.0e3 * l + 0.5 * t;
    else        ps = 12.0e-12 + 3.0e3 * l + 0.5 * t;
    np = rnd(ps / CLK);
    if (np < 1) np = 1;
    mx = (longint'(1) << cnt_w) - 1;
    tot = (nd + np > mx) ? mx : nd + np;
  endtask

  task automatic run_edge(input bit rising, input real tt, input real dl, input real c,
                          input string tag);
    longint nd, np, tot;
    int lat;
    model(tt, dl, c, rising, 20, nd, np, tot);
    lat = 3 + int'(tot);
    @(negedge clk);
    tt_val = tt; delay_val = dl; load_val = c; din = rising;
    if (rising) exp_q.push_back(np[31:0]);
    repeat (3) @(posedge clk);
    #1;
    tt_val = real'($urandom_range(0, 200)) * 1.0e-12;
    delay_val = real'($urandom_range(0, 500)) * 1.0e-12;
    load_val = real'($urandom_range(0, 42)) * 1.0e-15;
    repeat (lat - 4) @(posedge clk);
    #1 check({tag, "_pre"}, real'(dout), rising ? 1.0 : 0.0);
    @(posedge clk);
    #1 check({tag, "_out"}, real'(dout), rising ? 0.0 : 1.0);
    if (rising) last_fall = real'(exp_q.pop_front()) * CLK;
    check({tag, "_prop"}, prop, last_fall);
  endtask

  task automatic glitch(input bit base, input string tag);
    int k;
    bit saw;
    @(negedge clk);
    tt_val = 100.0e-12; load_val = 11.0e-15; delay_val = 0.0;
    din = !base;
    k = $urandom_range(1, 19);
    repeat (k) @(negedge clk);
    din = base;
    saw = 1'b0;
    repeat (400) begin
      @(posedge clk);
      #1 if (dout != !base) saw = 1'b1;
    end
    check({tag, "_dout"}, real'(saw), 0.0);
    check({tag, "_prop"}, prop, last_fall);
  endtask

  initial begin
    longint nd, np, tot, nd_s, np_s, tot_s;
    real slopes[7];
    real loads[7];
    slopes = '{0.001e-9, 0.01e-9, 0.03e-9, 0.06e-9, 0.1e-9, 0.15e-9, 0.2e-9};
    loads  = '{0.02e-15, 0.5e-15, 2.0e-15, 5.0e-15, 12.0e-15, 25.0e-15, 42.0e-15};

    repeat (3) @(negedge clk);
    #1 check("rst_dout", real'(dout), 1.0);
    check("rst_prop", prop, 0.0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("hold_dout", real'(dout), 1.0);
    check("hold_prop", prop, 0.0);

    run_edge(1'b1, 1.0e-12, 0.0, 0.02e-15, "d1f");
    check("d1_prop_abs", prop, 11.0e-12);
    run_edge(1'b0, 1.0e-12, 0.0, 0.02e-15, "d1r");
    check("d1r_prop_abs", prop, 11.0e-12);
    run_edge(1'b1, 200.0e-12, 0.0, 42.0e-15, "d2f");
    check("d2_prop_abs", prop, 194.0e-12);
    run_edge(1'b0, 200.0e-12, 0.0, 42.0e-15, "d2r");
    run_edge(1'b1, 70.0e-12, 1.0e-9, 5.0e-15, "d3f");
    check("d3_prop_abs", prop, 55.0e-12);
    run_edge(1'b0, 70.0e-12, 0.0, 5.0e-15, "d3r");

    // Counter saturation on the 8-bit copy; the main instance runs the full count.
    model(0.0, 1.0e-9, 0.0, 1'b1, 20, nd, np, tot);
    model(0.0, 1.0e-9, 0.0, 1'b1, 8, nd_s, np_s, tot_s);
    @(negedge clk);
    tt_val = 0.0; delay_val = 1.0e-9; load_val = 0.0; din = 1'b1;
    repeat (2 + int'(tot_s)) @(posedge clk);
    #1 check("sat_pre", real'(dout_s), 1.0);
    @(posedge clk);
    #1 check("sat_out", real'(dout_s), 0.0);
    check("sat_prop", prop_s, real'(np_s) * CLK);
    repeat (int'(tot) - int'(tot_s) - 1) @(posedge clk);
    #1 check("long_pre", real'(dout), 1.0);
    @(posedge clk);
    #1 check("long_out", real'(dout), 0.0);
    last_fall = real'(np) * CLK;
    check("long_prop", prop, last_fall);
    run_edge(1'b0, 0.0, 0.0, 0.0, "long_r");

    run_edge(1'b1, -5.0e-12, -1.0e-9, -1.0e-15, "neg_f");
    check("neg_prop_abs", prop, 10.0e-12);
    run_edge(1'b0, -5.0e-12, -1.0e-9, -1.0e-15, "neg_r");

    glitch(1'b0, "glitch_hi");
    run_edge(1'b1, 20.0e-12, 0.0, 3.0e-15, "pre_glo");
    glitch(1'b1, "glitch_lo");
    run_edge(1'b0, 20.0e-12, 0.0, 3.0e-15, "post_glo");

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7; j++) begin
        real dl;
        dl = real'($urandom_range(0, 20)) * 1.0e-12;
        run_edge(1'b1, slopes[i], dl, loads[j], $sformatf("sw%0d_%0d_f", i, j));
        repeat ($urandom_range(0, 20)) @(posedge clk);
        run_edge(1'b0, slopes[i], dl, loads[j], $sformatf("sw%0d_%0d_r", i, j));
        repeat ($urandom_range(0, 20)) @(posedge clk);
      end
    end

    @(negedge clk);
    tt_val = 50.0e-12; load_val = 10.0e-15; delay_val = 0.0; din = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; din = 1'b0;
    #1 check("mrst_dout", real'(dout), 1.0);
    check("mrst_prop", prop, 0.0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1 check("mrst_hold_dout", real'(dout), 1.0);
    check("mrst_hold_prop", prop, 0.0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
